// File: rtl/cache_refill_ctrl_if.sv
// CPU-side request and memory fill signals of the cache refill controller.
// The slave view belongs to the controller, and the master view belongs to whatever drives it.
interface cache_refill_ctrl_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic        hit;
    logic [4:0]  offset;
    logic        mem_ack;
    logic        stall;
    logic        mem_req;
    logic [4:0]  mem_byte;
    logic        regWrite;
    logic [31:0] byte_en;
    logic        hit_sel;
    logic        valid_set;
    logic        fill_err;

    modport slave (
        input  cpu_req, cpu_wr, hit, offset, mem_ack,
        output stall, mem_req, mem_byte, regWrite, byte_en, hit_sel, valid_set, fill_err
    );

    modport master (
        output cpu_req, cpu_wr, hit, offset, mem_ack,
        input  stall, mem_req, mem_byte, regWrite, byte_en, hit_sel, valid_set, fill_err
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Refills one 32-byte cache line, one byte at a time, after a miss.
// Store hits are served in the same cycle, and a stalled access repeats once the line is valid.
module cache_refill_ctrl #(
    parameter int LINE_BYTES  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_refill_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [4:0] LAST_BYTE    = 5'(LINE_BYTES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cntNext;
    logic [7:0]  r_wcnt;
    logic [7:0]  w_wcntNext;
    logic        w_req;
    logic [31:0] w_offsetOneHot;
    logic [31:0] w_cntOneHot;

    // While reset is asserted, a held request must not appear on the outputs.
    assign w_req          = bus.cpu_req & reset;
    assign w_offsetOneHot = 32'h1 << bus.offset;
    assign w_cntOneHot    = 32'h1 << r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_wcnt  <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cntNext;
            r_wcnt  <= w_wcntNext;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cntNext  = r_cnt;
        w_wcntNext = r_wcnt;
        case (r_state)
            IDLE: begin
                if (w_req && !bus.hit) begin
                    w_next     = FILL;
                    w_cntNext  = 5'd0;
                    w_wcntNext = 8'd0;
                end
            end
            FILL: begin
                // The request inputs are ignored here, so withdrawing the request does not cut the fill short.
                if (bus.mem_ack) begin
                    w_cntNext  = r_cnt + 5'd1;
                    w_wcntNext = 8'd0;
                    if (r_cnt == LAST_BYTE) begin
                        w_next = DONE;
                    end
                end else begin
                    w_wcntNext = r_wcnt + 8'd1;
                    if (r_wcnt == TIMEOUT_LAST) begin
                        w_next = ABORT;
                    end
                end
            end
            DONE, ABORT: begin
                w_next     = IDLE;
                w_cntNext  = 5'd0;
                w_wcntNext = 8'd0;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_byte  = 5'd0;
        bus.regWrite  = 1'b0;
        bus.byte_en   = 32'd0;
        bus.hit_sel   = 1'b0;
        bus.valid_set = 1'b0;
        bus.fill_err  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.hit_sel = 1'b1;
                if (w_req) begin
                    if (bus.hit) begin
                        if (bus.cpu_wr) begin
                            bus.regWrite = 1'b1;
                            bus.byte_en  = w_offsetOneHot;
                        end
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
            end
            FILL: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_byte = r_cnt;
                if (bus.mem_ack) begin
                    bus.regWrite = 1'b1;
                    bus.byte_en  = w_cntOneHot;
                end
            end
            DONE: begin
                bus.stall     = 1'b1;
                bus.valid_set = 1'b1;
            end
            ABORT: begin
                bus.stall    = 1'b1;
                bus.fill_err = 1'b1;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl. It uses a table of single-cycle vectors plus hand-written
// multi-cycle sequences for a full refill, an ack timeout and a reset in the middle of a fill.
module tb_cache_refill_ctrl;

    logic clk;
    logic rstN;
    int   numCompared;
    int   numMismatched;
    int   stallCycles;

    cache_refill_ctrl_if bus();

    cache_refill_ctrl #(
        .LINE_BYTES (32),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk  (clk),
        .reset(rstN),
        .bus  (bus.slave)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        req;
        logic        wr;
        logic        hit;
        logic [4:0]  off;
        logic        ack;
        logic        eStall;
        logic        eMemReq;
        logic [4:0]  eByte;
        logic        eRw;
        logic [31:0] eBe;
        logic        eHs;
        logic        eVs;
        logic        eFe;
    } vec_t;

    vec_t vecs[12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(string name, logic rst, logic req, logic wr, logic hit,
                                logic [4:0] off, logic ack, logic eStall, logic eMemReq,
                                logic [4:0] eByte, logic eRw, logic [31:0] eBe,
                                logic eHs, logic eVs, logic eFe);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.wr = wr; v.hit = hit; v.off = off; v.ack = ack;
        v.eStall = eStall; v.eMemReq = eMemReq; v.eByte = eByte; v.eRw = eRw; v.eBe = eBe;
        v.eHs = eHs; v.eVs = eVs; v.eFe = eFe;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic req, input logic wr,
                                 input logic hit, input logic [4:0] off, input logic ack);
        rstN        = rst;
        bus.cpu_req = req;
        bus.cpu_wr  = wr;
        bus.hit     = hit;
        bus.offset  = off;
        bus.mem_ack = ack;
    endtask

    task automatic compare(input string nm, input string field,
                           input logic [31:0] act, input logic [31:0] exp);
        numCompared++;
        if (act !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", nm, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string nm, input logic eStall, input logic eMemReq,
                               input logic [4:0] eByte, input logic eRw, input logic [31:0] eBe,
                               input logic eHs, input logic eVs, input logic eFe);
        compare(nm, "stall",     {31'd0, bus.stall},     {31'd0, eStall});
        compare(nm, "mem_req",   {31'd0, bus.mem_req},   {31'd0, eMemReq});
        compare(nm, "mem_byte",  {27'd0, bus.mem_byte},  {27'd0, eByte});
        compare(nm, "regWrite",  {31'd0, bus.regWrite},  {31'd0, eRw});
        compare(nm, "byte_en",   bus.byte_en,            eBe);
        compare(nm, "hit_sel",   {31'd0, bus.hit_sel},   {31'd0, eHs});
        compare(nm, "valid_set", {31'd0, bus.valid_set}, {31'd0, eVs});
        compare(nm, "fill_err",  {31'd0, bus.fill_err},  {31'd0, eFe});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2 rstN = 1'b0;

        //               name            rst  req  wr   hit  off    ack  stall mreq byte  rw   be              hs   vs   fe
        vecs[0]  = mk("reset_mask",    0,   1,   1,   1,   5'd5,  1,   0,    0,   5'd0, 0,   32'h0,          1,   0,   0);
        vecs[1]  = mk("idle_quiet",    1,   0,   0,   0,   5'd0,  0,   0,    0,   5'd0, 0,   32'h0,          1,   0,   0);
        vecs[2]  = mk("wr_hit_off5",   1,   1,   1,   1,   5'd5,  0,   0,    0,   5'd0, 1,   32'h0000_0020,  1,   0,   0);
        vecs[3]  = mk("rd_hit_off7",   1,   1,   0,   1,   5'd7,  0,   0,    0,   5'd0, 0,   32'h0,          1,   0,   0);
        vecs[4]  = mk("wr_hit_off31",  1,   1,   1,   1,   5'd31, 0,   0,    0,   5'd0, 1,   32'h8000_0000,  1,   0,   0);
        vecs[5]  = mk("wr_hit_off0",   1,   1,   1,   1,   5'd0,  1,   0,    0,   5'd0, 1,   32'h0000_0001,  1,   0,   0);
        vecs[6]  = mk("miss",          1,   1,   0,   0,   5'd12, 0,   1,    0,   5'd0, 0,   32'h0,          1,   0,   0);
        vecs[7]  = mk("fill_ack0",     1,   1,   1,   1,   5'd9,  1,   1,    1,   5'd0, 1,   32'h0000_0001,  0,   0,   0);
        vecs[8]  = mk("fill_gap_a",    1,   1,   1,   1,   5'd9,  0,   1,    1,   5'd1, 0,   32'h0,          0,   0,   0);
        vecs[9]  = mk("fill_gap_b",    1,   1,   0,   0,   5'd9,  0,   1,    1,   5'd1, 0,   32'h0,          0,   0,   0);
        vecs[10] = mk("fill_ack1",     1,   1,   0,   0,   5'd9,  1,   1,    1,   5'd1, 1,   32'h0000_0002,  0,   0,   0);
        vecs[11] = mk("fill_ack2",     1,   1,   0,   0,   5'd9,  1,   1,    1,   5'd2, 1,   32'h0000_0004,  0,   0,   0);

        nextCycle();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].wr, vecs[i].hit, vecs[i].off, vecs[i].ack);
            #1;
            checkOutput(vecs[i].name, vecs[i].eStall, vecs[i].eMemReq, vecs[i].eByte, vecs[i].eRw,
                        vecs[i].eBe, vecs[i].eHs, vecs[i].eVs, vecs[i].eFe);
            nextCycle();
        end

        // The request is withdrawn at cnt=3, and the fill still has to complete.
        for (int n = 3; n < 32; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
            #1;
            checkOutput($sformatf("withdrawn_byte%0d", n), 1, 1, 5'(n), 1, 32'h1 << n, 0, 0, 0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("withdrawn_done", 1, 0, 5'd0, 0, 32'h0, 0, 1, 0);
        nextCycle();
        #1;
        checkOutput("withdrawn_idle", 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        nextCycle();

        // Full refill with mem_ack high on every cycle, followed by a replay that hits.
        stallCycles = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1);
        #1;
        checkOutput("refill_miss", 1, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        stallCycles += int'(bus.stall);
        nextCycle();
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1);
            #1;
            checkOutput($sformatf("refill_byte%0d", n), 1, 1, 5'(n), 1, 32'h1 << n, 0, 0, 0);
            stallCycles += int'(bus.stall);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1);
        #1;
        checkOutput("refill_done", 1, 0, 5'd0, 0, 32'h0, 0, 1, 0);
        stallCycles += int'(bus.stall);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
        #1;
        checkOutput("refill_replay", 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        stallCycles += int'(bus.stall);
        nextCycle();
        compare("refill", "stall_cycles", 32'(stallCycles), 32'd34);

        // With no ack at all, the fill aborts after 255 waiting cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
        #1;
        checkOutput("timeout_miss", 1, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        for (int n = 0; n < 255; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
            #1;
            checkOutput($sformatf("timeout_wait%0d", n), 1, 1, 5'd0, 0, 32'h0, 0, 0, 0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("timeout_abort", 1, 0, 5'd0, 0, 32'h0, 0, 0, 1);
        nextCycle();
        #1;
        checkOutput("timeout_idle", 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        nextCycle();

        // Reset is asserted at cnt=17, away from the clock edge, while the request is still held.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0);
        #1;
        checkOutput("rstfill_miss", 1, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        for (int n = 0; n < 17; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
            #1;
            checkOutput($sformatf("rstfill_byte%0d", n), 1, 1, 5'(n), 1, 32'h1 << n, 0, 0, 0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
        #1;
        checkOutput("rstfill_byte17", 1, 1, 5'd17, 1, 32'h0002_0000, 0, 0, 0);
        #1 rstN = 1'b0;
        #1;
        checkOutput("rstfill_async", 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        checkOutput("rstfill_held", 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
        #1;
        checkOutput("rstfill_idle_miss", 1, 0, 5'd0, 0, 32'h0, 1, 0, 0);
        nextCycle();
        for (int n = 0; n < 32; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
            #1;
            checkOutput($sformatf("rstfill_restart%0d", n), 1, 1, 5'(n), 1, 32'h1 << n, 0, 0, 0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("rstfill_done", 1, 0, 5'd0, 0, 32'h0, 0, 1, 0);
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
